// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scan driver.
package seg7_scan_driver_pkg;

`include "seg7_defs.vh"

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned HEX_W      = 4;

    // Frame snapshot taken at the 3->0 wrap so a refresh never mixes old and new data.
    typedef struct packed {
        logic [NUM_DIGITS-1:0][HEX_W-1:0] val;
        logic [NUM_DIGITS-1:0]            dp;
        logic [NUM_DIGITS-1:0]            blank;
    } shadow_t;

    localparam shadow_t SHADOW_RST = '{val: '0, dp: 4'h0, blank: 4'hF};

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex-to-segment decoder, active-low outputs with dp on bit 7.
module hex_to_7seg
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] hex_i,
    input  logic       dp_i,
    output logic [7:0] seg_c_o
);

    always_comb begin
        seg_c_o = SEG_OFF;
        case (hex_i)
            4'h0: seg_c_o = SEG_HEX_0;
            4'h1: seg_c_o = SEG_HEX_1;
            4'h2: seg_c_o = SEG_HEX_2;
            4'h3: seg_c_o = SEG_HEX_3;
            4'h4: seg_c_o = SEG_HEX_4;
            4'h5: seg_c_o = SEG_HEX_5;
            4'h6: seg_c_o = SEG_HEX_6;
            4'h7: seg_c_o = SEG_HEX_7;
            4'h8: seg_c_o = SEG_HEX_8;
            4'h9: seg_c_o = SEG_HEX_9;
            4'hA: seg_c_o = SEG_HEX_A;
            4'hB: seg_c_o = SEG_HEX_B;
            4'hC: seg_c_o = SEG_HEX_C;
            4'hD: seg_c_o = SEG_HEX_D;
            4'hE: seg_c_o = SEG_HEX_E;
            4'hF: seg_c_o = SEG_HEX_F;
            default: seg_c_o = SEG_OFF;
        endcase
        if (dp_i) seg_c_o[7] = 1'b0;
    end

endmodule

// File: rtl/seg7_defs.vh
// Shared segment constants: active-low hex glyphs, dark segment word and all-off enables.
`ifndef SEG7_DEFS_VH
`define SEG7_DEFS_VH

localparam logic [7:0] SEG_OFF   = 8'hFF;
localparam logic [3:0] EN_OFF    = 4'hF;

localparam logic [7:0] SEG_HEX_0 = 8'hC0;
localparam logic [7:0] SEG_HEX_1 = 8'hF9;
localparam logic [7:0] SEG_HEX_2 = 8'hA4;
localparam logic [7:0] SEG_HEX_3 = 8'hB0;
localparam logic [7:0] SEG_HEX_4 = 8'h99;
localparam logic [7:0] SEG_HEX_5 = 8'h92;
localparam logic [7:0] SEG_HEX_6 = 8'h82;
localparam logic [7:0] SEG_HEX_7 = 8'hF8;
localparam logic [7:0] SEG_HEX_8 = 8'h80;
localparam logic [7:0] SEG_HEX_9 = 8'h90;
localparam logic [7:0] SEG_HEX_A = 8'h88;
localparam logic [7:0] SEG_HEX_B = 8'h83;
localparam logic [7:0] SEG_HEX_C = 8'hC6;
localparam logic [7:0] SEG_HEX_D = 8'hA1;
localparam logic [7:0] SEG_HEX_E = 8'h86;
localparam logic [7:0] SEG_HEX_F = 8'h8E;

`endif

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with guard-band dark time, frame-coherent
// shadowing of the inputs and optional leading-zero suppression.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 12000000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter bit          LZ_BLANK     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_0_in,
    input  logic [3:0] digit_1_in,
    input  logic [3:0] digit_2_in,
    input  logic [3:0] digit_3_in,
    input  logic [3:0] dp_in,
    input  logic [3:0] blank_in,
    output logic [3:0] en_disp,
    output logic [7:0] digit_out
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    shadow_t          sh_q, sh_d;
    logic             first_q;
    logic [3:0]       en_q, en_d;
    logic [7:0]       seg_q, seg_d;

    logic             wrap;
    logic [3:0]       hex_c;
    logic             dp_c;
    logic [7:0]       dec_c;
    logic [3:0]       lz_c;

    hex_to_7seg u_dec (
        .hex_i   (hex_c),
        .dp_i    (dp_c),
        .seg_c_o (dec_c)
    );

    // Scan sequencing, shadow reload and next output word.
    always_comb begin
        wrap  = (cnt_q == CNT_W'(DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;

        sh_d = sh_q;
        if (first_q || (wrap && (idx_q == 2'd3))) begin
            sh_d.val   = {digit_3_in, digit_2_in, digit_1_in, digit_0_in};
            sh_d.dp    = dp_in;
            sh_d.blank = blank_in;
        end

        hex_c = sh_q.val[idx_q];
        dp_c  = sh_q.dp[idx_q];

        // A digit is a leading zero only if it and every more-significant digit are 0 without dp.
        lz_c    = 4'h0;
        lz_c[3] = (sh_q.val[3] == 4'h0) && !sh_q.dp[3];
        lz_c[2] = lz_c[3] && (sh_q.val[2] == 4'h0) && !sh_q.dp[2];
        lz_c[1] = lz_c[2] && (sh_q.val[1] == 4'h0) && !sh_q.dp[1];
        if (!LZ_BLANK) lz_c = 4'h0;

        en_d  = EN_OFF;
        seg_d = SEG_OFF;
        if (cnt_q >= CNT_W'(GUARD_CYCLES)) begin
            en_d = ~(4'b0001 << idx_q);
            if (!(sh_q.blank[idx_q] || lz_c[idx_q])) seg_d = dec_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            sh_q    <= SHADOW_RST;
            first_q <= 1'b1;
            en_q    <= EN_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            first_q <= 1'b0;
            en_q    <= en_d;
            seg_q   <= seg_d;
        end
    end

    assign en_disp   = en_q;
    assign digit_out = seg_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 12000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter REFRESH_HZ, default 1000, meaning the per-digit slot rate in Hz; DIV = CLK_FREQ_HZ/REFRESH_HZ SHALL be at least 8.
REQ-003 The block SHALL have parameter GUARD_CYCLES, default 2, meaning the anti-ghost dark cycles at slot start; it SHALL be less than DIV.
REQ-004 The block SHALL have parameter LZ_BLANK, default 0, where 1 enables leading-zero suppression.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have ports digit_0_in..digit_3_in, input, 4 bits each: hex values, where digit_3 is the most significant digit.
REQ-008 The block SHALL have port dp_in, input, 4 bits: decimal point per digit, active-high.
REQ-009 The block SHALL have port blank_in, input, 4 bits: forced per-digit blank, active-high.
REQ-010 The block SHALL have port en_disp, output, 4 bits: digit enables, active-low, where bit i drives digit i.
REQ-011 The block SHALL have port digit_out, output, 8 bits: segments, active-low, bit7=dp, bits6..0={g,f,e,d,c,b,a}.

Function
REQ-012 The slot counter SHALL count 0..DIV-1 and wrap; on wrap, digit index SHALL advance 0->1->2->3->0.
REQ-013 A shadow register (4 values, dp, blank) SHALL load from the inputs on the cycle the index wraps 3->0, and on the first clock edge after reset deassertion; inputs SHALL NOT affect outputs at any other time (no tearing).
REQ-014 During slot counts 0..GUARD_CYCLES-1, en_disp SHALL be 4'b1111 and digit_out SHALL be 8'hFF.
REQ-015 For the remaining counts, en_disp SHALL assert only bit idx low, and digit_out SHALL show the decoded shadow value of idx.
REQ-016 A blanked digit (shadow blank, or LZ) SHALL drive digit_out 8'hFF while its enable still follows REQ-015.
REQ-017 When LZ_BLANK=1: digit 3 SHALL blank if its value is 0 and its dp is 0; digit 2 SHALL blank if digits 3..2 are 0 with no dp among them; digit 1 likewise for digits 3..1; digit 0 SHALL never blank by LZ.
REQ-018 The hex decode (active-low, dp off) SHALL be: 0->C0, 1->F9, 2->A4, 3->B0, 4->99, 5->92, 6->82, 7->F8, 8->80, 9->90, A->88, b->83, C->C6, d->A1, E->86, F->8E; dp=1 SHALL clear bit7.
REQ-019 Outputs SHALL be registered, lagging the counter/index state by exactly one clock.
REQ-020 Counter width SHALL be clog2(DIV); no arithmetic overflow beyond DIV-1 is permitted.

Reset
REQ-021 While rst=0, counter=0, idx=0, shadow values=0, shadow blank=4'b1111, en_disp=4'b1111 and digit_out=8'hFF, applied immediately.
REQ-022 A mid-slot reset SHALL abort the scan; after release the scan SHALL restart at slot 0, count 0, with a fresh shadow load.

Structure
REQ-023 Segment constants (the hex table, SEG_OFF=8'hFF, EN_OFF=4'hF) SHALL reside in shared include seg7_defs.vh.
REQ-024 Decoding SHALL be a combinational sub-module hex_to_7seg (4-bit in, dp in, 8-bit out), instantiated once on the muxed value.

Verification (CLK_FREQ_HZ=100000, REFRESH_HZ=1000, DIV=100, GUARD_CYCLES=2)
REQ-025 The bench SHALL check: reset held, then released with inputs 1,2,3,4 -> outputs FF/1111 during reset; after release, en_disp cycles 1110,1101,1011,0111 every 100 clocks, with digit_out F9,A4,B0,99.
REQ-026 The bench SHALL check: counts 0..1 of every slot -> en_disp=1111 and digit_out=FF; count 2 -> enable low.
REQ-027 The bench SHALL check: digit_0_in changed from 1 to 8 during slot 1 -> digit 0 still shows F9 until the next 3->0 wrap, then shows 80.
REQ-028 The bench SHALL check: LZ_BLANK=1, inputs 0,0,0,5 (d3..d0) -> digits 3..1 FF, digit 0 92; with dp_in[2]=1 -> digit 2 shows 40 and digit 1 shows C0.
REQ-029 The bench SHALL check: blank_in=4'b0100 -> digit 2 slot shows FF with en_disp=1011.
REQ-030 The bench SHALL check: rst pulsed low at count 50 of slot 2 -> outputs FF/1111 asynchronously; after release, digit 0 is enabled at count 2.
